// File: rtl/sigdelay_pkg.sv
// sigdelay_pkg: shared FSM state type and delay helper for sigdelay_mc.
// Used by the sigdelay_mc top and its dly_ram sub-module.
package sigdelay_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN
    } state_t;

    // Requested delay of zero collapses to one sample; callers truncate to A_WIDTH.
    function automatic logic [31:0] delay_eff(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/sigdelay_mc_dly_ram.sv
// dly_ram: simple dual-port sample RAM with registered read.
// Same-address read and write in one cycle returns the old contents.
module dly_ram
    import sigdelay_pkg::*;
#(
    parameter int A_WIDTH = 9,
    parameter int D_WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [A_WIDTH-1:0] i_waddr,
    input  logic [D_WIDTH-1:0] i_wdata,
    input  logic               i_re,
    input  logic [A_WIDTH-1:0] i_raddr,
    output logic [D_WIDTH-1:0] o_rdata
);

    logic [D_WIDTH-1:0] r_mem [2**A_WIDTH];

    // No reset here: stale contents are masked by the fill phase in the top.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/sigdelay_mc.sv
// sigdelay_mc: multi-channel sample delay line with one shared pointer/fill FSM.
// Optional echo feedback is selected by defining SIGDELAY_ECHO_EN.
module sigdelay_mc
    import sigdelay_pkg::*;
#(
    parameter int A_WIDTH = 9,
    parameter int D_WIDTH = 8,
    parameter int CH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [A_WIDTH-1:0]    delay,
    input  logic [CH*D_WIDTH-1:0] din,
    output logic [CH*D_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  filling
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [A_WIDTH-1:0] r_wr_ptr;
    logic [A_WIDTH-1:0] r_delay_q;
    logic [A_WIDTH-1:0] r_fill_cnt;
    logic [A_WIDTH-1:0] w_fill_nxt;
    logic [A_WIDTH:0]   w_fill_inc;
    logic [A_WIDTH-1:0] w_delay_eff;
    logic [A_WIDTH-1:0] w_rd_addr;
    logic               r_dout_valid;
    logic               w_run;

    assign w_delay_eff = A_WIDTH'(delay_eff(32'(delay)));
    assign w_rd_addr   = r_wr_ptr - w_delay_eff;
    assign w_fill_inc  = {1'b0, r_fill_cnt} + {{A_WIDTH{1'b0}}, 1'b1};
    assign w_run       = (r_state == S_RUN);

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill_cnt;
        if (en) begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_FILL;
                    w_fill_nxt  = '0;
                end
                S_FILL: begin
                    // The strobe that completes the fill already reads valid data.
                    if (w_fill_inc >= {1'b0, w_delay_eff}) begin
                        w_state_nxt = S_RUN;
                    end else if (r_fill_cnt != '1) begin
                        w_fill_nxt = w_fill_inc[A_WIDTH-1:0];
                    end
                end
                S_RUN: begin
                    if (delay != r_delay_q) begin
                        w_state_nxt = S_FILL;
                        w_fill_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_fill_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_delay_q    <= '0;
            r_fill_cnt   <= '0;
            r_dout_valid <= 1'b0;
        end else if (en) begin
            r_wr_ptr     <= r_wr_ptr + 1'b1;
            r_delay_q    <= delay;
            r_fill_cnt   <= w_fill_nxt;
            r_dout_valid <= (w_state_nxt == S_RUN);
        end else begin
            r_dout_valid <= 1'b0;
        end
    end

    assign dout_valid = r_dout_valid;
    assign filling    = (r_state == S_FILL);

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [D_WIDTH-1:0] w_din_lane;
        logic [D_WIDTH-1:0] w_ram_q;
        logic [D_WIDTH-1:0] w_dout_lane;
        logic [D_WIDTH-1:0] w_wdata;

        assign w_din_lane  = din[k*D_WIDTH +: D_WIDTH];
        // State only changes on a strobe, so gating by state keeps dout stable while en=0.
        assign w_dout_lane = w_run ? w_ram_q : '0;
        assign dout[k*D_WIDTH +: D_WIDTH] = w_dout_lane;

`ifdef SIGDELAY_ECHO_EN
        logic [D_WIDTH:0] w_sum;
        assign w_sum   = {1'b0, w_din_lane} + {2'b00, w_dout_lane[D_WIDTH-1:1]};
        assign w_wdata = !w_run ? w_din_lane :
                         (w_sum[D_WIDTH] ? '1 : w_sum[D_WIDTH-1:0]);
`else
        assign w_wdata = w_din_lane;
`endif

        dly_ram #(
            .A_WIDTH(A_WIDTH),
            .D_WIDTH(D_WIDTH)
        ) u_ram (
            .i_clk  (clk),
            .i_we   (en),
            .i_waddr(r_wr_ptr),
            .i_wdata(w_wdata),
            .i_re   (en),
            .i_raddr(w_rd_addr),
            .o_rdata(w_ram_q)
        );
    end

endmodule
